// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath defaults and the MEM-stage control bundle.
package mips_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_AW_DEF     = 5;
    localparam int DMEM_DEPTH_DEF = 256;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump_reg;
    } mem_ctrl_t;

endpackage

// File: rtl/data_mem.sv
// Single-port synchronous data RAM with a registered, read-before-write output.
module data_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The read samples the array before this edge's write lands, so a
    // same-cycle hit returns the old word.
    always_ff @(posedge clk) begin
        rdata <= mem[addr];
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: data-memory access, branch/jr redirect, and the MEM/WB pipeline register.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              branch_in,
    input  logic              jump_reg_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic [DATA_W-1:0] data2_in,
    input  logic [REG_AW-1:0] write_addr_in,
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target,
    output logic              reg_write_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [REG_AW-1:0] write_addr_out,
    output logic              align_err
);

    localparam int IDX_W = $clog2(DMEM_DEPTH);

    mem_ctrl_t         ctrl;
    logic              misaligned;
    logic              store_en;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] load_data;
    logic              mem_to_reg_q;
    logic [DATA_W-1:0] result_q;

    assign ctrl = '{reg_write:  reg_write_in,
                    mem_to_reg: mem_to_reg_in,
                    mem_read:   mem_read_in,
                    mem_write:  mem_write_in,
                    branch:     branch_in,
                    jump_reg:   jump_reg_in};

    assign pc_src    = ~rst & ((ctrl.branch & zero_in) | ctrl.jump_reg);
    assign pc_target = ctrl.jump_reg ? result_in : pc_in;

    // Word index; address bits above the RAM size wrap.
    assign idx        = result_in[2 +: IDX_W];
    assign misaligned = (ctrl.mem_read | ctrl.mem_write) & (|result_in[1:0]);
    assign store_en   = ctrl.mem_write & ~misaligned & ~rst;

    data_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DMEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_dmem (
        .clk   (clk),
        .we    (store_en),
        .addr  (idx),
        .wdata (data2_in),
        .rdata (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_out  <= 1'b0;
            write_addr_out <= '0;
            mem_to_reg_q   <= 1'b0;
            result_q       <= '0;
            align_err      <= 1'b0;
        end else begin
            reg_write_out  <= ctrl.reg_write & ~misaligned;
            write_addr_out <= write_addr_in;
            mem_to_reg_q   <= ctrl.mem_to_reg;
            result_q       <= result_in;
            if (misaligned) align_err <= 1'b1;
        end
    end

    // RAM output is already registered, so the write-back mux sits after it.
    assign wb_data_out = mem_to_reg_q ? load_data : result_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a reference memory and an expected-result queue.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in;
    logic        branch_in, jump_reg_in, zero_in;
    logic [31:0] pc_in, result_in, data2_in;
    logic [4:0]  write_addr_in;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        reg_write_out;
    logic [31:0] wb_data_out;
    logic [4:0]  write_addr_out;
    logic        align_err;

    typedef struct {
        logic        rw;
        logic [31:0] wb;
        logic [4:0]  wa;
        logic        ae;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [256];
    logic        ae_model = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .branch_in(branch_in), .jump_reg_in(jump_reg_in), .zero_in(zero_in),
        .pc_in(pc_in), .result_in(result_in), .data2_in(data2_in),
        .write_addr_in(write_addr_in),
        .pc_src(pc_src), .pc_target(pc_target),
        .reg_write_out(reg_write_out), .wb_data_out(wb_data_out),
        .write_addr_out(write_addr_out), .align_err(align_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One pipeline cycle: drive, check redirect combinationally, clock, check MEM/WB.
    task automatic step(input string tag, input logic r,
                        input logic rw, input logic m2r, input logic rd, input logic wr,
                        input logic br, input logic jr, input logic z,
                        input logic [31:0] pc, input logic [31:0] res,
                        input logic [31:0] d2, input logic [4:0] wa);
        exp_t        e;
        logic        mis;
        logic [7:0]  ix;
        logic [31:0] old;
        rst = r; reg_write_in = rw; mem_to_reg_in = m2r; mem_read_in = rd;
        mem_write_in = wr; branch_in = br; jump_reg_in = jr; zero_in = z;
        pc_in = pc; result_in = res; data2_in = d2; write_addr_in = wa;
        mis = (rd | wr) & (res[1:0] != 2'b00);
        ix  = res[9:2];
        old = model[ix];
        if (wr && !mis && !r) model[ix] = d2;
        if (r) begin
            ae_model = 1'b0;
            e = '{rw: 1'b0, wb: 32'h0, wa: 5'h0, ae: 1'b0};
        end else begin
            if (mis) ae_model = 1'b1;
            e = '{rw: rw & ~mis, wb: m2r ? old : res, wa: wa, ae: ae_model};
        end
        sb.push_back(e);
        #1;
        check({tag, ".pc_src"}, {31'h0, pc_src}, {31'h0, ~r & ((br & z) | jr)});
        check({tag, ".pc_target"}, pc_target, jr ? res : pc);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            check({tag, ".reg_write_out"}, {31'h0, reg_write_out}, {31'h0, e.rw});
            check({tag, ".wb_data_out"}, wb_data_out, e.wb);
            check({tag, ".write_addr_out"}, {27'h0, write_addr_out}, {27'h0, e.wa});
            check({tag, ".align_err"}, {31'h0, align_err}, {31'h0, e.ae});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        @(negedge clk);
        //        tag       rst rw m2r rd wr br jr z  pc          result        data2         wa
        step("reset0",   1, 0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h0,        5'd0);
        step("prestore", 0, 0, 0, 0, 1, 0, 0, 0, 32'h0,      32'h20,       32'hCAFE0001, 5'd0);
        step("rst_st1",  1, 1, 1, 0, 1, 0, 0, 0, 32'h0,      32'h20,       32'h00000BAD, 5'd7);
        step("rst_st2",  1, 1, 0, 0, 1, 1, 1, 1, 32'h44,     32'h20,       32'h00000BAD, 5'd7);
        step("ld_pre",   0, 1, 1, 1, 0, 0, 0, 0, 32'h0,      32'h20,       32'h0,        5'd3);
        step("st_10",    0, 0, 0, 0, 1, 0, 0, 0, 32'h0,      32'h10,       32'hDEADBEEF, 5'd0);
        step("ld_10",    0, 1, 1, 1, 0, 0, 0, 0, 32'h0,      32'h10,       32'h0,        5'd5);
        step("rtype",    0, 1, 0, 0, 0, 0, 0, 0, 32'h0,      32'h1234,     32'h55555555, 5'd9);
        step("ld_10b",   0, 1, 1, 1, 0, 0, 0, 0, 32'h0,      32'h10,       32'h0,        5'd6);
        step("br_tk",    0, 0, 0, 0, 0, 1, 0, 1, 32'h40,     32'h0,        32'h0,        5'd0);
        step("br_nt",    0, 0, 0, 0, 0, 1, 0, 0, 32'h40,     32'h0,        32'h0,        5'd0);
        step("jr",       0, 0, 0, 0, 0, 0, 1, 0, 32'h40,     32'h80,       32'h0,        5'd0);
        step("br_jr",    0, 0, 0, 0, 0, 1, 1, 1, 32'h40,     32'hC0,       32'h0,        5'd0);
        step("wa0",      0, 1, 0, 0, 0, 0, 0, 0, 32'h0,      32'h77,       32'h0,        5'd0);
        step("mis_ld",   0, 1, 1, 1, 0, 0, 0, 0, 32'h0,      32'h13,       32'h0,        5'd4);
        step("mis_st",   0, 0, 0, 0, 1, 0, 0, 0, 32'h0,      32'h22,       32'h11111111, 5'd0);
        step("ld_20",    0, 1, 1, 1, 0, 0, 0, 0, 32'h0,      32'h20,       32'h0,        5'd8);
        step("sticky",   0, 1, 0, 0, 0, 0, 0, 0, 32'h0,      32'h100,      32'h0,        5'd2);
        step("rst_ae",   1, 0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h0,        5'd0);
        step("st_wrap",  0, 0, 0, 0, 1, 0, 0, 0, 32'h0,      32'h400,      32'h0A0B0C0D, 5'd0);
        step("ld_0",     0, 1, 1, 1, 0, 0, 0, 0, 32'h0,      32'h0,        32'h0,        5'd10);
        step("rdwr",     0, 1, 1, 1, 1, 0, 0, 0, 32'h0,      32'h0,        32'h12345678, 5'd11);
        step("ld_0b",    0, 1, 1, 1, 0, 0, 0, 0, 32'h0,      32'h400,      32'h0,        5'd12);
        step("bubble",   0, 0, 0, 0, 0, 0, 0, 0, 32'h0,      32'h0,        32'h0,        5'd0);
        check("sb_drained", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
